// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM states
//   dmem_req_t   : request fields latched at acceptance
//   WORD_ALIGN_MASK, mask_bytes() : address alignment and byte-lane masking
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEM_REQ,
      MEM_WAIT,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic        is_write;
   } dmem_req_t;

   localparam logic [31:0] WORD_ALIGN_MASK = 32'hfffffffc;

   // Zero every byte lane of data whose mask bit is clear.
   function automatic logic [31:0] mask_bytes(input logic [31:0] data,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_timeout_counter.sv
// Watchdog counter for the MEM_WAIT phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at zero
//   en         : count this cycle (waiting, no response yet)
//   expire     : high in the last allowed waiting cycle; never high when
//                TIMEOUT_CYCLES is 0. TCNT_W must satisfy 2^TCNT_W > TIMEOUT_CYCLES.
module dmem_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TCNT_W         = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [TCNT_W-1:0] LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [TCNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);

endmodule

// File: rtl/dmem_responder.sv
// Responder for the core's data-memory request interface. A one-cycle
// request pulse is latched, issued as a single word transaction on the
// valid/ready backing port, and answered with a one-cycle dmem_resp.
//   dmem_addr/rmask/wmask/wdata : request pulse from load/store arbitration
//   dmem_rdata/resp/err, busy   : registered completion and status
//   mem_valid/ready/we/addr/wdata/wstrb/resp/rdata : backing-memory port
//   proto_err                   : sticky protocol-violation flag
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TCNT_W         = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic        dmem_err,
   output logic        busy,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_resp,
   input  logic [31:0] mem_rdata,
   output logic        proto_err
);

   dmem_state_t state;
   dmem_req_t   req_q;

   logic req;
   logic tmo_clr;
   logic tmo_en;
   logic tmo_expire;

   assign req     = (|dmem_rmask) || (|dmem_wmask);
   assign tmo_clr = (state == MEM_REQ) && mem_ready;
   assign tmo_en  = (state == MEM_WAIT) && !mem_resp;

   dmem_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TCNT_W         (TCNT_W)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   // The backing port is driven straight from the latched request, so it
   // stays stable for as long as mem_valid waits on mem_ready.
   assign mem_we    = req_q.is_write;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;
   assign mem_wstrb = req_q.is_write ? req_q.wmask : 4'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the latched request is reset too, because mem_addr,
         // mem_wdata and mem_wstrb are observable and must read zero in reset.
         state      <= IDLE;
         req_q      <= '0;
         dmem_rdata <= '0;
         dmem_resp  <= 1'b0;
         dmem_err   <= 1'b0;
         busy       <= 1'b0;
         mem_valid  <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         // dmem_resp/dmem_err are one-cycle pulses unless re-asserted below.
         dmem_resp <= 1'b0;
         dmem_err  <= 1'b0;

         // A request while busy is dropped; a backing response outside
         // MEM_WAIT (e.g. left over from an abandoned transaction) is ignored.
         if ((req && state != IDLE) || (mem_resp && state != MEM_WAIT)) begin
            proto_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (req) begin
                  req_q <= '{addr:     dmem_addr & WORD_ALIGN_MASK,
                             wdata:    dmem_wdata,
                             rmask:    dmem_rmask,
                             wmask:    dmem_wmask,
                             is_write: |dmem_wmask};
                  // Both masks set: executed as a write, flagged as misuse.
                  if ((|dmem_rmask) && (|dmem_wmask)) begin
                     proto_err <= 1'b1;
                  end
                  mem_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= MEM_REQ;
               end
            end

            MEM_REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= MEM_WAIT;
               end
            end

            MEM_WAIT: begin
               if (mem_resp) begin
                  dmem_rdata <= mask_bytes(mem_rdata,
                                           req_q.is_write ? 4'h0 : req_q.rmask);
                  dmem_resp  <= 1'b1;
                  state      <= RESP;
               end else if (tmo_expire) begin
                  dmem_rdata <= '0;
                  dmem_resp  <= 1'b1;
                  dmem_err   <= 1'b1;
                  state      <= RESP;
               end
            end

            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic against a byte-addressed reference memory, with a scoreboard
// monitor for dmem_resp and a backing-memory model that checks the bus.
module tb_dmem_responder;

   localparam int TO = 8;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_bus_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        dmem_err;
   logic        busy;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_resp;
   logic [31:0] mem_rdata;
   logic        proto_err;

   int n_checks = 0;
   int n_errors = 0;

   exp_resp_t sb_q[$];
   exp_bus_t  bus_q[$];
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] bmem    [int unsigned];

   // Backing-model configuration, set by the stimulus before each request.
   int cfg_rdly   = 0;
   int cfg_sdly   = 0;
   bit cfg_drop   = 0;
   int stray_cnt  = 0;
   bit exp_proto  = 0;

   dmem_responder #(
      .TIMEOUT_CYCLES (TO),
      .TCNT_W         (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dmem_addr  (dmem_addr),
      .dmem_rmask (dmem_rmask),
      .dmem_wmask (dmem_wmask),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_resp  (dmem_resp),
      .dmem_err   (dmem_err),
      .busy       (busy),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_resp   (mem_resp),
      .mem_rdata  (mem_rdata),
      .proto_err  (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Initial contents of a word never written, shared by model and backing memory.
   function automatic logic [31:0] init_word(input int unsigned w);
      return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // ---------------- scoreboard monitor ----------------
   exp_resp_t mon_er;
   initial begin
      forever begin
         @(negedge clk);
         if (dmem_resp === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_dmem_resp", 32'(dmem_resp), 32'd0);
            end else begin
               mon_er = sb_q.pop_front();
               check("dmem_rdata", dmem_rdata, mon_er.rdata);
               check("dmem_err", 32'(dmem_err), 32'(mon_er.err));
            end
         end
      end
   end

   // ---------------- backing memory model ----------------
   exp_bus_t    bk_eb;
   int          stray_done = 0;
   int unsigned bk_w;
   logic [31:0] bk_word;
   initial begin
      mem_ready = 1'b0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_resp = 1'b0;
         if (stray_cnt != stray_done) begin
            stray_done++;
            mem_resp  = 1'b1;
            mem_rdata = $urandom;
         end else if (mem_valid === 1'b1) begin
            if (bus_q.size() == 0) begin
               check("unexpected_mem_valid", 32'(mem_valid), 32'd0);
               bk_eb = '{addr: mem_addr, we: mem_we, wdata: mem_wdata, wstrb: mem_wstrb};
            end else begin
               bk_eb = bus_q.pop_front();
               check("mem_addr", mem_addr, bk_eb.addr);
               check("mem_we", 32'(mem_we), 32'(bk_eb.we));
               check("mem_wstrb", 32'(mem_wstrb), 32'(bk_eb.wstrb));
               if (bk_eb.we) check("mem_wdata", mem_wdata, bk_eb.wdata);
            end
            repeat (cfg_rdly) begin
               @(negedge clk);
               check("mem_valid_held", 32'(mem_valid), 32'd1);
               check("mem_addr_stable", mem_addr, bk_eb.addr);
               check("mem_wstrb_stable", 32'(mem_wstrb), 32'(bk_eb.wstrb));
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            if (!cfg_drop) begin
               repeat (cfg_sdly) @(negedge clk);
               bk_w    = mem_addr / 4;
               bk_word = bmem.exists(bk_w) ? bmem[bk_w] : init_word(bk_w);
               if (mem_we) begin
                  for (int i = 0; i < 4; i++)
                     if (mem_wstrb[i]) bk_word[8*i +: 8] = mem_wdata[8*i +: 8];
                  bmem[bk_w] = bk_word;
                  mem_rdata  = $urandom;
               end else begin
                  mem_rdata = bk_word;
               end
               mem_resp = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_req();
      dmem_addr  = '0;
      dmem_rmask = '0;
      dmem_wmask = '0;
      dmem_wdata = '0;
   endtask

   // Issue one request at the current negedge and wait for its response.
   // poke > 0 injects an extra request pulse that many cycles later.
   task automatic do_txn(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input int rdly, input int sdly,
                         input bit drop, input int poke);
      exp_resp_t   er;
      exp_bus_t    eb;
      int unsigned w;
      logic [31:0] wv;
      int          lat;
      int          exp_lat;
      w  = addr / 4;
      wv = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
      eb.addr  = w * 4;
      eb.wdata = wd;
      er.rdata = '0;
      er.err   = 1'b0;
      if (wm != 0) begin
         eb.we    = 1'b1;
         eb.wstrb = wm;
         for (int i = 0; i < 4; i++) if (wm[i]) wv[8*i +: 8] = wd[8*i +: 8];
         ref_mem[w] = wv;
         if (rm != 0) exp_proto = 1'b1;
      end else begin
         eb.we    = 1'b0;
         eb.wstrb = 4'h0;
         for (int i = 0; i < 4; i++) if (rm[i]) er.rdata[8*i +: 8] = wv[8*i +: 8];
      end
      if (drop) begin
         er.rdata = '0;
         er.err   = 1'b1;
      end
      exp_lat  = drop ? (2 + rdly + TO) : (3 + rdly + sdly);
      cfg_rdly = rdly;
      cfg_sdly = sdly;
      cfg_drop = drop;
      sb_q.push_back(er);
      bus_q.push_back(eb);
      dmem_addr  = addr;
      dmem_rmask = rm;
      dmem_wmask = wm;
      dmem_wdata = wd;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         clear_req();
         if (lat == poke) begin
            dmem_addr  = $urandom;
            dmem_rmask = 4'h2;
            exp_proto  = 1'b1;
         end
      end while (dmem_resp !== 1'b1 && lat < 200);
      clear_req();
      check("latency", 32'(lat), 32'(exp_lat));
      @(negedge clk);
      check("busy_after_resp", 32'(busy), 32'd0);
      check("proto_err", 32'(proto_err), 32'(exp_proto));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "time limit");
   end

   logic [31:0] r_addr;
   logic [3:0]  r_rm, r_wm;
   int          kind;
   exp_bus_t    rst_eb;

   initial begin
      rst_n = 1'b0;
      clear_req();
      repeat (3) @(negedge clk);
      check("reset_status", {26'd0, dmem_resp, dmem_err, busy, mem_valid, mem_we, proto_err}, 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      check("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
      rst_n = 1'b1;

      // Basic read after a full-word write: minimum latency, masked data.
      do_txn(32'h0000_1004, 4'h0, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
      do_txn(32'h0000_1006, 4'b0011, 4'h0, 32'h0, 0, 0, 0, 0);
      // Write with three cycles of backpressure.
      do_txn(32'h0000_2000, 4'h0, 4'b1000, 32'hAB000000, 3, 1, 0, 0);
      do_txn(32'h0000_2000, 4'hF, 4'h0, 32'h0, 0, 2, 0, 0);
      // Watchdog: no backing response at all.
      do_txn(32'h0000_1000, 4'hF, 4'h0, 32'h0, 0, 0, 1, 0);
      // Response in the very last allowed waiting cycle still wins.
      do_txn(32'h0000_1004, 4'hF, 4'h0, 32'h0, 1, TO - 1, 0, 0);
      // Request pulse while waiting, then a dual-mask request.
      do_txn(32'h0000_1004, 4'b1100, 4'h0, 32'h0, 0, 5, 0, 4);
      do_txn(32'h0000_2004, 4'hF, 4'h1, 32'h1234_5678, 0, 0, 0, 0);
      do_txn(32'h0000_2004, 4'hF, 4'h0, 32'h0, 0, 0, 0, 0);

      // Reset while the backing transaction is outstanding.
      cfg_drop = 1'b1;
      cfg_rdly = 0;
      cfg_sdly = 0;
      rst_eb   = '{addr: 32'h0000_3000, we: 1'b0, wdata: 32'h0, wstrb: 4'h0};
      bus_q.push_back(rst_eb);
      dmem_addr  = 32'h0000_3000;
      dmem_rmask = 4'hF;
      @(negedge clk);
      clear_req();
      repeat (3) @(negedge clk);
      check("busy_before_reset", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_status", {26'd0, dmem_resp, dmem_err, busy, mem_valid, mem_we, proto_err}, 32'd0);
      check("async_reset_rdata", dmem_rdata, 32'd0);
      check("async_reset_mem_addr", mem_addr, 32'd0);
      check("async_reset_mem_wdata", mem_wdata, 32'd0);
      check("async_reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      exp_proto = 1'b0;
      stray_cnt++;
      repeat (4) @(negedge clk);
      check("stray_resp_proto_err", 32'(proto_err), 32'd1);
      check("stray_resp_busy", 32'(busy), 32'd0);
      exp_proto = 1'b1;
      do_txn(32'h0000_1004, 4'hF, 4'h0, 32'h0, 0, 0, 0, 0);

      // Random traffic over a small address window.
      for (int k = 0; k < 60; k++) begin
         r_addr = (32'($urandom_range(0, 31)) * 4) + 32'($urandom_range(0, 3));
         kind   = $urandom_range(0, 9);
         r_rm   = 4'h0;
         r_wm   = 4'h0;
         if (kind < 4 || kind == 9) r_rm = 4'($urandom_range(1, 15));
         else if (kind < 8)         r_wm = 4'($urandom_range(1, 15));
         else begin
            r_rm = 4'($urandom_range(1, 15));
            r_wm = 4'($urandom_range(1, 15));
         end
         do_txn(r_addr, r_rm, r_wm, $urandom, $urandom_range(0, 3),
                $urandom_range(0, TO - 1), (kind == 9), 0);
      end

      repeat (2) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("bus_drained", 32'(bus_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
